pwm_capture: RTL and testbench
==============================

# pwm_capture

PWM duty-cycle capture block: samples an external or on-chip PWM waveform on a single clock and reports the high time and period of every completed PWM period, in clock cycles. It is the measuring end of the team's PWM generator path. It closes the loop in self-checking benches and gives firmware readback of a PWM line. A constant-level input is detected by timeout and flagged as stuck-low or stuck-high.

## Interface
- `R`, default 8: nominal resolution. A PWM generator with parameter R has a period of 2**R cycles.
- `TIMEOUT`, default 2**(R+1): number of cycles without a rising edge before the input is declared stuck. Legal range is 2 to 2**(R+2)-1.
- `clk`  in  1: sole clock; all logic is rising-edge triggered.
- `reset`  in  1: asynchronous, active-high reset.
- `pwm_in`  in  1: PWM input. It may be asynchronous to `clk`.
- `high_cnt`  out  R+2: cycles `pwm_in` was high in the last completed period.
- `period_cnt`  out  R+2: cycles between the last two rising edges.
- `valid`  out  1: one-cycle pulse when `high_cnt`, `period_cnt` or the stuck flags are updated.
- `stuck_low`  out  1: input held low for TIMEOUT cycles.
- `stuck_high`  out  1: input held high for TIMEOUT cycles.

## Operation
- Synchronizer: `s1`, `s2` form a 2-FF synchronizer on `pwm_in`. `s3` holds the previous value of `s2`.
- Edge detect: `rise = s2 & ~s3`.
- Counters: `pcnt` and `hcnt`, both R+2 bits.
  - On `rise`: `pcnt <= 1`, `hcnt <= 1`.
  - Otherwise: `pcnt <= pcnt+1` and `hcnt <= hcnt + s2`.
  - Both saturate at all-ones and never wrap.
- FSM has three states: WAIT_EDGE, MEASURE, STUCK.
  - WAIT_EDGE is the reset state. On `rise`, go to MEASURE and start the counters. No `valid` is issued, because the first edge only arms the block.
  - MEASURE, on `rise`:
    - Latch `high_cnt <= hcnt` and `period_cnt <= pcnt` (values before the counter restart).
    - Pulse `valid`.
    - Stay in MEASURE.
  - MEASURE, no `rise` and `pcnt == TIMEOUT`:
    - Go to STUCK.
    - Set `high_cnt = 0` and `period_cnt = 0`.
    - Set `stuck_high = s2` and `stuck_low = ~s2`.
    - Pulse `valid` once.
  - WAIT_EDGE, no `rise` and `pcnt == TIMEOUT`: same action as in MEASURE. This way a line that is low from reset is reported.
  - STUCK:
    - Stuck flags follow `s2`, registered, with no further `valid`.
    - On `rise`: clear both flags, go to MEASURE, restart the counters. No `valid` on this edge.
- `rise` and timeout in the same cycle: `rise` wins. The period is latched as TIMEOUT. The maximum measurable period is TIMEOUT.
- Invariants:
  - `high_cnt <= period_cnt`.
  - At most one of `stuck_low` / `stuck_high` is set.
- Counter width arithmetic: R+2 bits holds TIMEOUT up to 2**(R+2)-1 without overflow.

## Timing
- Reset values: all outputs 0; `s1`/`s2`/`s3` 0; `pcnt`/`hcnt` 0; state WAIT_EDGE.
- Reset is asserted asynchronously and released synchronously by the environment.
- Reset mid-operation aborts any measurement with no `valid`. Latched results are lost.
- If `pwm_in` is high at reset release, a `rise` is seen 2 cycles later. This only arms the block.
- Latency: a `pwm_in` rising edge first sampled at clock edge k produces `rise` after edge k+1. `valid`/`high_cnt`/`period_cnt` update after edge k+2.
- `valid` spacing equals the input period. Outputs hold between `valid` pulses.
- Timeout `valid` appears TIMEOUT+1 edges after the last `rise`.
- Input pulses shorter than one `clk` period may be missed. This is accepted, not flagged.

## Structure
- Package `pwm_pkg` holds:
  - the state enum `pwm_cap_state_t` (WAIT_EDGE, MEASURE, STUCK);
  - a localparam function for counter width (R+2);
  - the default TIMEOUT expression.
- Sub-module `pwm_sync_edge`: 2-FF synchronizer plus rise/fall detect, with async active-high reset. It is reused by other input-capture blocks.
- The top level holds the counters, the FSM and the output registers.

## Test plan
All scenarios use R=8, TIMEOUT=512, generator period 256.
- Generator duty=64 after reset: no `valid` on the first rising edge. Then every 256 cycles `valid` with `high_cnt=64`, `period_cnt=256`, both stuck flags 0.
- Duty changes 64 → 128 → 192 (each held 512 cycles): the first full period after each change reports 128/256, then 192/256. No intermediate `valid` is malformed.
- Duty=0 from reset (line low): exactly one `valid` 513 cycles after reset release with `stuck_low=1`, `high_cnt=0`, `period_cnt=0`. Then duty=64: the flag clears on the first rising edge, and the next `valid` reports 64/256.
- `pwm_in` forced high for 600 cycles mid-run: `stuck_high=1` with a single `valid`. Release to PWM: flags clear on the rise, and the measurement resumes with correct values.
- Reset asserted mid-period (cycle 100 of a period): all outputs go to 0 immediately. No `valid` until the second rising edge after release.
- Period exactly 512 cycles (high 10): `valid` reports 10/512 with no stuck flag, because rise beats timeout.

Source files
------------

// File: rtl/pwm_pkg.sv
// Shared types and sizing helpers for the PWM capture path.
package pwm_pkg;

  // Capture FSM states: waiting for the arming edge, measuring, or stuck.
  typedef enum logic [1:0] {
    WAIT_EDGE = 2'd0,
    MEASURE   = 2'd1,
    STUCK     = 2'd2
  } pwm_cap_state_t;

  // Counter width for resolution r: two extra bits so that a timeout of up
  // to 2**(r+2)-1 cycles is representable without overflow.
  function automatic int cnt_width(input int r);
    return r + 2;
  endfunction

  // Default stuck timeout: twice the nominal generator period.
  function automatic int default_timeout(input int r);
    return 1 << (r + 1);
  endfunction

endpackage

// File: rtl/pwm_sync_edge.sv
// Two-flop synchronizer for an asynchronous level input, plus one extra
// history flop used to detect rising and falling edges of the synchronized
// level. Shared by the input-capture blocks.
module pwm_sync_edge (
  input  logic clk,
  input  logic reset,
  input  logic din,
  output logic level,
  output logic rise,
  output logic fall
);

  logic s1;
  logic s2;
  logic s3;

  // Synchronizer chain (s1, s2) followed by the previous-value flop s3.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      s1 <= 1'b0;
      s2 <= 1'b0;
      s3 <= 1'b0;
    end else begin
      s1 <= din;
      s2 <= s1;
      s3 <= s2;
    end
  end

  assign level = s2;
  assign rise  = s2 & ~s3;
  assign fall  = ~s2 & s3;

endmodule

// File: rtl/pwm_capture.sv
// PWM duty-cycle capture: measures high time and period of each completed
// PWM period in clock cycles, and flags a line that stops toggling as
// stuck-low or stuck-high after TIMEOUT cycles without a rising edge.
// TIMEOUT must lie in 2 .. 2**(R+2)-1 so it fits the counter width.
module pwm_capture
  import pwm_pkg::*;
#(
  parameter int R       = 8,
  parameter int TIMEOUT = default_timeout(R)
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         pwm_in,
  output logic [R+1:0] high_cnt,
  output logic [R+1:0] period_cnt,
  output logic         valid,
  output logic         stuck_low,
  output logic         stuck_high
);

  localparam int W = cnt_width(R);
  localparam logic [W-1:0] CNT_MAX     = '1;
  localparam logic [W-1:0] TIMEOUT_CNT = W'(TIMEOUT);

  logic           level;
  logic           rise;
  logic           fall;
  logic [W-1:0]   pcnt;
  logic [W-1:0]   hcnt;
  logic           timeout_hit;
  logic           latch_meas;
  logic           enter_stuck;
  pwm_cap_state_t state;
  pwm_cap_state_t state_next;

  pwm_sync_edge u_sync (
    .clk   (clk),
    .reset (reset),
    .din   (pwm_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  assign timeout_hit = (pcnt == TIMEOUT_CNT);

  // Period and high-time counters: restart at 1 on every rising edge (the
  // edge cycle itself is high), otherwise count up and saturate.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pcnt <= '0;
      hcnt <= '0;
    end else if (rise) begin
      pcnt <= W'(1);
      hcnt <= W'(1);
    end else begin
      if (pcnt != CNT_MAX) begin
        pcnt <= pcnt + W'(1);
      end
      if (level && (hcnt != CNT_MAX)) begin
        hcnt <= hcnt + W'(1);
      end
    end
  end

  // FSM state register.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state <= WAIT_EDGE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; a rising edge always takes priority over timeout so
  // a period of exactly TIMEOUT is still measured.
  always_comb begin
    state_next  = state;
    latch_meas  = 1'b0;
    enter_stuck = 1'b0;
    case (state)
      WAIT_EDGE: begin
        if (rise) begin
          state_next = MEASURE;
        end else if (timeout_hit) begin
          state_next  = STUCK;
          enter_stuck = 1'b1;
        end
      end
      MEASURE: begin
        if (rise) begin
          latch_meas = 1'b1;
        end else if (timeout_hit) begin
          state_next  = STUCK;
          enter_stuck = 1'b1;
        end
      end
      STUCK: begin
        if (rise) begin
          state_next = MEASURE;
        end
      end
      default: begin
        state_next = WAIT_EDGE;
      end
    endcase
  end

  // Result and flag registers. Inside STUCK the line can only change by a
  // falling edge (a rising edge leaves STUCK), so following the level there
  // reduces to switching the flags to stuck-low on a fall.
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      high_cnt   <= '0;
      period_cnt <= '0;
      valid      <= 1'b0;
      stuck_low  <= 1'b0;
      stuck_high <= 1'b0;
    end else begin
      valid <= latch_meas | enter_stuck;
      if (latch_meas) begin
        high_cnt   <= hcnt;
        period_cnt <= pcnt;
      end else if (enter_stuck) begin
        high_cnt   <= '0;
        period_cnt <= '0;
        stuck_high <= level;
        stuck_low  <= ~level;
      end else if (state == STUCK) begin
        if (rise) begin
          stuck_high <= 1'b0;
          stuck_low  <= 1'b0;
        end else if (fall) begin
          stuck_high <= 1'b0;
          stuck_low  <= 1'b1;
        end
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Directed bench for pwm_capture with R=8, TIMEOUT=512.
module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       reset;
  logic       pwm_in;
  logic [9:0] high_cnt;
  logic [9:0] period_cnt;
  logic       valid;
  logic       stuck_low;
  logic       stuck_high;

  int checks   = 0;
  int failures = 0;

  int         cyc = 0;
  int         vcount = 0;
  int         bad_count = 0;
  int         last_vcyc = 0;
  int         prev_vcyc = 0;
  logic [9:0] last_high = '0;
  logic [9:0] last_period = '0;
  logic       last_sl = 1'b0;
  logic       last_sh = 1'b0;

  pwm_capture #(.R(8), .TIMEOUT(512)) dut (
    .clk        (clk),
    .reset      (reset),
    .pwm_in     (pwm_in),
    .high_cnt   (high_cnt),
    .period_cnt (period_cnt),
    .valid      (valid),
    .stuck_low  (stuck_low),
    .stuck_high (stuck_high)
  );

  always #5 clk = ~clk;

  // Clock edges since the last reset release.
  always @(posedge clk or posedge reset) begin
    if (reset) cyc <= 0;
    else       cyc <= cyc + 1;
  end

  // Record every valid pulse, sampled mid-cycle.
  always @(negedge clk) begin
    if (valid === 1'b1) begin
      vcount      = vcount + 1;
      prev_vcyc   = last_vcyc;
      last_vcyc   = cyc;
      last_high   = high_cnt;
      last_period = period_cnt;
      last_sl     = stuck_low;
      last_sh     = stuck_high;
      if ((high_cnt > period_cnt) || (stuck_low && stuck_high)) bad_count = bad_count + 1;
    end
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "[TB] watchdog");
  end

  task automatic run_pwm(input int duty, input int period, input int nper);
    for (int p = 0; p < nper; p++) begin
      for (int i = 0; i < period; i++) begin
        @(negedge clk);
        pwm_in = (i < duty);
      end
    end
  endtask

  task automatic hold_level(input logic lvl, input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge clk);
      pwm_in = lvl;
    end
  endtask

  task automatic do_reset();
    @(negedge clk);
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    reset  = 1'b1;
    pwm_in = 1'b0;
    repeat (3) @(negedge clk);
    checks++; if (high_cnt !== 10'd0)   begin failures++; $display("FAIL reset_high_cnt got=%0d exp=0", high_cnt); end
    checks++; if (period_cnt !== 10'd0) begin failures++; $display("FAIL reset_period_cnt got=%0d exp=0", period_cnt); end
    checks++; if (valid !== 1'b0)       begin failures++; $display("FAIL reset_valid got=%b exp=0", valid); end
    checks++; if (stuck_low !== 1'b0)   begin failures++; $display("FAIL reset_stuck_low got=%b exp=0", stuck_low); end
    checks++; if (stuck_high !== 1'b0)  begin failures++; $display("FAIL reset_stuck_high got=%b exp=0", stuck_high); end
    reset = 1'b0;
  endtask

  task automatic test_duty64();
    int v0;
    v0 = vcount;
    run_pwm(64, 256, 1);
    checks++; if (vcount !== v0) begin failures++; $display("FAIL first_edge_no_valid got=%0d exp=%0d", vcount, v0); end
    run_pwm(64, 256, 3);
    checks++; if (vcount !== v0 + 3) begin failures++; $display("FAIL duty64_count got=%0d exp=%0d", vcount, v0 + 3); end
    checks++; if (last_high !== 10'd64) begin failures++; $display("FAIL duty64_high got=%0d exp=64", last_high); end
    checks++; if (last_period !== 10'd256) begin failures++; $display("FAIL duty64_period got=%0d exp=256", last_period); end
    checks++; if ({last_sl, last_sh} !== 2'b00) begin failures++; $display("FAIL duty64_flags got=%b%b exp=00", last_sl, last_sh); end
    checks++; if (last_vcyc - prev_vcyc !== 256) begin failures++; $display("FAIL duty64_spacing got=%0d exp=256", last_vcyc - prev_vcyc); end
  endtask

  task automatic test_duty_change();
    int v0;
    v0 = vcount;
    run_pwm(128, 256, 2);
    checks++; if (vcount !== v0 + 2) begin failures++; $display("FAIL duty128_count got=%0d exp=%0d", vcount, v0 + 2); end
    checks++; if (last_high !== 10'd128) begin failures++; $display("FAIL duty128_high got=%0d exp=128", last_high); end
    run_pwm(192, 256, 2);
    checks++; if (last_high !== 10'd192) begin failures++; $display("FAIL duty192_high got=%0d exp=192", last_high); end
    checks++; if (last_period !== 10'd256) begin failures++; $display("FAIL duty192_period got=%0d exp=256", last_period); end
    checks++; if (bad_count !== 0) begin failures++; $display("FAIL malformed_valids got=%0d exp=0", bad_count); end
  endtask

  task automatic test_stuck_low();
    int v0;
    do_reset();
    v0 = vcount;
    hold_level(1'b0, 600);
    checks++; if (vcount !== v0 + 1) begin failures++; $display("FAIL stuck_low_count got=%0d exp=%0d", vcount, v0 + 1); end
    checks++; if (last_vcyc !== 513) begin failures++; $display("FAIL stuck_low_latency got=%0d exp=513", last_vcyc); end
    checks++; if ({last_sl, last_sh} !== 2'b10) begin failures++; $display("FAIL stuck_low_flags got=%b%b exp=10", last_sl, last_sh); end
    checks++; if ({last_high, last_period} !== 20'd0) begin failures++; $display("FAIL stuck_low_counts got=%0d/%0d exp=0/0", last_high, last_period); end
    checks++; if (stuck_low !== 1'b1) begin failures++; $display("FAIL stuck_low_live got=%b exp=1", stuck_low); end
    run_pwm(64, 256, 3);
    checks++; if (vcount !== v0 + 3) begin failures++; $display("FAIL stuck_low_recover_count got=%0d exp=%0d", vcount, v0 + 3); end
    checks++; if ({last_high, last_period} !== {10'd64, 10'd256}) begin failures++; $display("FAIL stuck_low_recover got=%0d/%0d exp=64/256", last_high, last_period); end
    checks++; if (stuck_low !== 1'b0) begin failures++; $display("FAIL stuck_low_cleared got=%b exp=0", stuck_low); end
  endtask

  task automatic test_stuck_high();
    int v0;
    v0 = vcount;
    hold_level(1'b1, 600);
    checks++; if (vcount !== v0 + 2) begin failures++; $display("FAIL stuck_high_count got=%0d exp=%0d", vcount, v0 + 2); end
    checks++; if ({last_sl, last_sh} !== 2'b01) begin failures++; $display("FAIL stuck_high_flags got=%b%b exp=01", last_sl, last_sh); end
    checks++; if ({last_high, last_period} !== 20'd0) begin failures++; $display("FAIL stuck_high_counts got=%0d/%0d exp=0/0", last_high, last_period); end
    checks++; if (stuck_high !== 1'b1) begin failures++; $display("FAIL stuck_high_live got=%b exp=1", stuck_high); end
    hold_level(1'b0, 10);
    checks++; if (vcount !== v0 + 2) begin failures++; $display("FAIL stuck_follow_no_valid got=%0d exp=%0d", vcount, v0 + 2); end
    checks++; if ({stuck_low, stuck_high} !== 2'b10) begin failures++; $display("FAIL stuck_follow_level got=%b%b exp=10", stuck_low, stuck_high); end
    run_pwm(64, 256, 3);
    checks++; if (vcount !== v0 + 4) begin failures++; $display("FAIL stuck_high_recover_count got=%0d exp=%0d", vcount, v0 + 4); end
    checks++; if ({last_high, last_period} !== {10'd64, 10'd256}) begin failures++; $display("FAIL stuck_high_recover got=%0d/%0d exp=64/256", last_high, last_period); end
    checks++; if ({stuck_low, stuck_high} !== 2'b00) begin failures++; $display("FAIL stuck_high_cleared got=%b%b exp=00", stuck_low, stuck_high); end
  endtask

  task automatic test_reset_mid();
    int v0;
    for (int i = 0; i < 100; i++) begin
      @(negedge clk);
      pwm_in = (i < 64);
    end
    #2;
    reset  = 1'b1;
    pwm_in = 1'b0;
    #1;
    checks++; if ({high_cnt, period_cnt} !== 20'd0) begin failures++; $display("FAIL midreset_counts got=%0d/%0d exp=0/0", high_cnt, period_cnt); end
    checks++; if ({valid, stuck_low, stuck_high} !== 3'b000) begin failures++; $display("FAIL midreset_flags got=%b%b%b exp=000", valid, stuck_low, stuck_high); end
    repeat (2) @(negedge clk);
    reset = 1'b0;
    v0 = vcount;
    run_pwm(64, 256, 1);
    checks++; if (vcount !== v0) begin failures++; $display("FAIL midreset_arm_no_valid got=%0d exp=%0d", vcount, v0); end
    run_pwm(64, 256, 1);
    checks++; if (vcount !== v0 + 1) begin failures++; $display("FAIL midreset_second_edge got=%0d exp=%0d", vcount, v0 + 1); end
    checks++; if ({last_high, last_period} !== {10'd64, 10'd256}) begin failures++; $display("FAIL midreset_meas got=%0d/%0d exp=64/256", last_high, last_period); end
  endtask

  task automatic test_period_512();
    int v0;
    v0 = vcount;
    run_pwm(10, 512, 3);
    checks++; if (vcount !== v0 + 3) begin failures++; $display("FAIL p512_count got=%0d exp=%0d", vcount, v0 + 3); end
    checks++; if ({last_high, last_period} !== {10'd10, 10'd512}) begin failures++; $display("FAIL p512_meas got=%0d/%0d exp=10/512", last_high, last_period); end
    checks++; if ({last_sl, last_sh} !== 2'b00) begin failures++; $display("FAIL p512_flags got=%b%b exp=00", last_sl, last_sh); end
    checks++; if (last_vcyc - prev_vcyc !== 512) begin failures++; $display("FAIL p512_spacing got=%0d exp=512", last_vcyc - prev_vcyc); end
  endtask

  initial begin
    test_reset();
    test_duty64();
    test_duty_change();
    test_stuck_low();
    test_stuck_high();
    test_reset_mid();
    test_period_512();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
